// File: rtl/class_result_merge_pkg.sv
// Shared types and constants for the classification result merge block.
// A FIFO entry packs the error flag, the hit flag and the FID/TID pointer.
package class_pkg;

  localparam int VT_AWIDTH_DEF = 15;

  typedef struct packed {
    logic                     err;
    logic                     hit_miss;
    logic [VT_AWIDTH_DEF-1:0] ptr;
  } class_res_t;

  localparam logic RES_SRC_HASH = 1'b0;
  localparam logic RES_SRC_TCAM = 1'b1;

endpackage

// File: rtl/class_result_merge_if.sv
// Lookup result inputs from both sources plus the merged valid/ready output.
// The merge block takes the slave side; whoever feeds and drains it takes the master side.
interface class_result_merge_if #(
  parameter int VT_AWIDTH = 15
);

  logic                 hash_vld;
  logic                 hash_err;
  logic                 hash_hit_miss;
  logic [VT_AWIDTH-1:0] hash_ptr;
  logic                 tcam_vld;
  logic                 tcam_err;
  logic                 tcam_hit_miss;
  logic [VT_AWIDTH-1:0] tcam_ptr;
  logic                 res_vld;
  logic                 res_ready;
  logic                 res_err;
  logic                 res_hit;
  logic                 res_src;
  logic [VT_AWIDTH-1:0] res_ptr;

  modport master (
    output hash_vld, hash_err, hash_hit_miss, hash_ptr,
    output tcam_vld, tcam_err, tcam_hit_miss, tcam_ptr,
    output res_ready,
    input  res_vld, res_err, res_hit, res_src, res_ptr
  );

  modport slave (
    input  hash_vld, hash_err, hash_hit_miss, hash_ptr,
    input  tcam_vld, tcam_err, tcam_hit_miss, tcam_ptr,
    input  res_ready,
    output res_vld, res_err, res_hit, res_src, res_ptr
  );

endinterface

// File: rtl/class_result_merge_fifo.sv
// In-order result FIFO. A push into a full FIFO is dropped unless a pop
// happens on the same edge, in which case the freed slot takes the new entry.
module class_res_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_en, rd_en;

  always_comb begin
    rd_en    = pop && (count_q != '0);
    wr_en    = push && ((count_q != (AW+1)'(DEPTH)) || rd_en);
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;

endmodule

// File: rtl/class_result_merge.sv
// Pairs one hash result with one TCAM result per packet, resolves priority
// (error, then exact-match hit, then TCAM hit) and keeps saturating statistics.
module class_result_merge
  import class_pkg::*;
#(
  parameter int VT_AWIDTH    = VT_AWIDTH_DEF,
  parameter int DEPTH        = 8,
  parameter int AFULL_MARGIN = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  class_result_merge_if.slave  bus,
  output logic                 merge_afull,
  output logic [1:0]           ovf_sticky,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] cnt_hash_hit,
  output logic [CNT_WIDTH-1:0] cnt_tcam_hit,
  output logic [CNT_WIDTH-1:0] cnt_miss,
  output logic [CNT_WIDTH-1:0] cnt_err
);

  localparam int EW = VT_AWIDTH + 2;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] AFULL_TH = CW'(DEPTH - AFULL_MARGIN);

  logic                 hash_in_vld_q, hash_in_vld_d;
  logic [EW-1:0]        hash_in_q, hash_in_d;
  logic                 tcam_in_vld_q, tcam_in_vld_d;
  logic [EW-1:0]        tcam_in_q, tcam_in_d;

  logic [EW-1:0]        h_dout, t_dout;
  logic                 h_empty, h_full, t_empty, t_full;
  logic [CW-1:0]        h_count, t_count;
  logic [CW-1:0]        h_cnt_nxt, t_cnt_nxt;
  logic                 h_wr, t_wr, h_drop, t_drop;
  logic                 pair_load, res_hs;

  logic                 res_vld_q, res_vld_d;
  logic                 res_err_q, res_err_d;
  logic                 res_hit_q, res_hit_d;
  logic                 res_src_q, res_src_d;
  logic [VT_AWIDTH-1:0] res_ptr_q, res_ptr_d;
  logic                 merge_afull_q, merge_afull_d;
  logic [1:0]           ovf_q, ovf_d;

  logic [CNT_WIDTH-1:0] cnt_hash_q, cnt_hash_d;
  logic [CNT_WIDTH-1:0] cnt_tcam_q, cnt_tcam_d;
  logic [CNT_WIDTH-1:0] cnt_miss_q, cnt_miss_d;
  logic [CNT_WIDTH-1:0] cnt_err_q, cnt_err_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Input capture stage: the extra register sets the two-edge pairing latency.
  always_comb begin
    hash_in_vld_d = bus.hash_vld;
    hash_in_d     = {bus.hash_err, bus.hash_hit_miss, bus.hash_ptr};
    tcam_in_vld_d = bus.tcam_vld;
    tcam_in_d     = {bus.tcam_err, bus.tcam_hit_miss, bus.tcam_ptr};
  end

  class_res_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_hash_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (hash_in_vld_q),
    .din   (hash_in_q),
    .pop   (pair_load),
    .dout  (h_dout),
    .empty (h_empty),
    .full  (h_full),
    .count (h_count)
  );

  class_res_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_tcam_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tcam_in_vld_q),
    .din   (tcam_in_q),
    .pop   (pair_load),
    .dout  (t_dout),
    .empty (t_empty),
    .full  (t_full),
    .count (t_count)
  );

  always_comb begin
    res_hs    = res_vld_q && bus.res_ready;
    pair_load = !h_empty && !t_empty && (!res_vld_q || bus.res_ready);

    res_vld_d = res_vld_q;
    res_err_d = res_err_q;
    res_hit_d = res_hit_q;
    res_src_d = res_src_q;
    res_ptr_d = res_ptr_q;
    if (pair_load) begin
      res_vld_d = 1'b1;
      res_err_d = 1'b0;
      res_hit_d = 1'b0;
      res_src_d = RES_SRC_HASH;
      res_ptr_d = '0;
      if (h_dout[EW-1] || t_dout[EW-1]) begin
        res_err_d = 1'b1;
      end else if (h_dout[EW-2]) begin
        res_hit_d = 1'b1;
        res_ptr_d = h_dout[VT_AWIDTH-1:0];
      end else if (t_dout[EW-2]) begin
        res_hit_d = 1'b1;
        res_src_d = RES_SRC_TCAM;
        res_ptr_d = t_dout[VT_AWIDTH-1:0];
      end
    end else if (res_hs) begin
      res_vld_d = 1'b0;
    end
  end

  // Throttle looks at the occupancy the FIFOs will have after this edge.
  always_comb begin
    h_wr   = hash_in_vld_q && (!h_full || pair_load);
    t_wr   = tcam_in_vld_q && (!t_full || pair_load);
    h_drop = hash_in_vld_q && h_full && !pair_load;
    t_drop = tcam_in_vld_q && t_full && !pair_load;
    h_cnt_nxt = h_count + CW'(h_wr) - CW'(pair_load);
    t_cnt_nxt = t_count + CW'(t_wr) - CW'(pair_load);
    merge_afull_d = (h_cnt_nxt >= AFULL_TH) || (t_cnt_nxt >= AFULL_TH);
    ovf_d = ovf_q | {t_drop, h_drop};
  end

  always_comb begin
    cnt_hash_d = cnt_hash_q;
    cnt_tcam_d = cnt_tcam_q;
    cnt_miss_d = cnt_miss_q;
    cnt_err_d  = cnt_err_q;
    if (cnt_clr) begin
      cnt_hash_d = '0;
      cnt_tcam_d = '0;
      cnt_miss_d = '0;
      cnt_err_d  = '0;
    end else if (res_hs) begin
      if (res_err_q)                      cnt_err_d  = sat_inc(cnt_err_q);
      else if (!res_hit_q)                cnt_miss_d = sat_inc(cnt_miss_q);
      else if (res_src_q == RES_SRC_TCAM) cnt_tcam_d = sat_inc(cnt_tcam_q);
      else                                cnt_hash_d = sat_inc(cnt_hash_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hash_in_vld_q <= 1'b0;
      hash_in_q     <= '0;
      tcam_in_vld_q <= 1'b0;
      tcam_in_q     <= '0;
      res_vld_q     <= 1'b0;
      res_err_q     <= 1'b0;
      res_hit_q     <= 1'b0;
      res_src_q     <= 1'b0;
      res_ptr_q     <= '0;
      merge_afull_q <= 1'b0;
      ovf_q         <= '0;
      cnt_hash_q    <= '0;
      cnt_tcam_q    <= '0;
      cnt_miss_q    <= '0;
      cnt_err_q     <= '0;
    end else begin
      hash_in_vld_q <= hash_in_vld_d;
      hash_in_q     <= hash_in_d;
      tcam_in_vld_q <= tcam_in_vld_d;
      tcam_in_q     <= tcam_in_d;
      res_vld_q     <= res_vld_d;
      res_err_q     <= res_err_d;
      res_hit_q     <= res_hit_d;
      res_src_q     <= res_src_d;
      res_ptr_q     <= res_ptr_d;
      merge_afull_q <= merge_afull_d;
      ovf_q         <= ovf_d;
      cnt_hash_q    <= cnt_hash_d;
      cnt_tcam_q    <= cnt_tcam_d;
      cnt_miss_q    <= cnt_miss_d;
      cnt_err_q     <= cnt_err_d;
    end
  end

  assign bus.res_vld   = res_vld_q;
  assign bus.res_err   = res_err_q;
  assign bus.res_hit   = res_hit_q;
  assign bus.res_src   = res_src_q;
  assign bus.res_ptr   = res_ptr_q;
  assign merge_afull   = merge_afull_q;
  assign ovf_sticky    = ovf_q;
  assign cnt_hash_hit  = cnt_hash_q;
  assign cnt_tcam_hit  = cnt_tcam_q;
  assign cnt_miss      = cnt_miss_q;
  assign cnt_err       = cnt_err_q;

endmodule

// File: tb/tb_class_result_merge.sv
// Scoreboard bench for class_result_merge, built with 4-bit counters so
// saturation is reachable; a monitor checks every handshaked result in order.
module tb_class_result_merge;

  localparam int AW = 15;
  localparam int CW = 4;

  typedef struct packed {
    logic          err;
    logic          hit;
    logic          src;
    logic [AW-1:0] ptr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cnt_clr = 1'b0;
  logic          merge_afull;
  logic [1:0]    ovf_sticky;
  logic [CW-1:0] cnt_hash_hit, cnt_tcam_hit, cnt_miss, cnt_err;

  exp_t expQ[$];
  exp_t monE;
  int   total = 0;
  int   bad = 0;

  class_result_merge_if #(.VT_AWIDTH(AW)) bus ();

  class_result_merge #(
    .VT_AWIDTH(AW), .DEPTH(8), .AFULL_MARGIN(2), .CNT_WIDTH(CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .merge_afull  (merge_afull),
    .ovf_sticky   (ovf_sticky),
    .cnt_clr      (cnt_clr),
    .cnt_hash_hit (cnt_hash_hit),
    .cnt_tcam_hit (cnt_tcam_hit),
    .cnt_miss     (cnt_miss),
    .cnt_err      (cnt_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pushExp(input logic err, input logic hit, input logic src, input logic [AW-1:0] ptr);
    exp_t e;
    e.err = err; e.hit = hit; e.src = src; e.ptr = ptr;
    expQ.push_back(e);
  endtask

  // Drives one cycle of strobes starting at a negedge; returns at the next negedge.
  task automatic applyStimulus(input logic hv, input logic he, input logic hh, input logic [AW-1:0] hp,
                               input logic tv, input logic te, input logic th, input logic [AW-1:0] tp);
    bus.hash_vld = hv; bus.hash_err = he; bus.hash_hit_miss = hh; bus.hash_ptr = hp;
    bus.tcam_vld = tv; bus.tcam_err = te; bus.tcam_hit_miss = th; bus.tcam_ptr = tp;
    @(negedge clk);
    bus.hash_vld = 1'b0;
    bus.tcam_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkCounters(input string tag, input int h, input int t, input int m, input int e);
    checkOutput({tag, "_cnt_hash"}, 32'(cnt_hash_hit), 32'(h));
    checkOutput({tag, "_cnt_tcam"}, 32'(cnt_tcam_hit), 32'(t));
    checkOutput({tag, "_cnt_miss"}, 32'(cnt_miss), 32'(m));
    checkOutput({tag, "_cnt_err"},  32'(cnt_err), 32'(e));
  endtask

  task automatic pulseClear();
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  // Samples mid low phase so stimulus changed at the negedge has settled.
  always @(negedge clk) begin
    #2;
    if (rst_n && bus.res_vld && bus.res_ready) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_result: got ptr 0x%0h, expected no result", bus.res_ptr);
      end else begin
        monE = expQ.pop_front();
        checkOutput("result", 32'({bus.res_err, bus.res_hit, bus.res_src, bus.res_ptr}), 32'(monE));
      end
    end
  end

  initial begin
    bus.hash_vld = 1'b0; bus.hash_err = 1'b0; bus.hash_hit_miss = 1'b0; bus.hash_ptr = '0;
    bus.tcam_vld = 1'b0; bus.tcam_err = 1'b0; bus.tcam_hit_miss = 1'b0; bus.tcam_ptr = '0;
    bus.res_ready = 1'b0;

    idle(3);
    checkOutput("rst_vld", 32'(bus.res_vld), 32'd0);
    checkOutput("rst_out", 32'({bus.res_err, bus.res_hit, bus.res_src, bus.res_ptr}), 32'd0);
    checkOutput("rst_afull", 32'(merge_afull), 32'd0);
    checkOutput("rst_ovf", 32'(ovf_sticky), 32'd0);
    checkCounters("rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    idle(1);

    $display("[TB] hash-only hit and latency");
    bus.res_ready = 1'b1;
    pushExp(1'b0, 1'b1, 1'b0, 15'h0123);
    applyStimulus(1'b1, 1'b0, 1'b1, 15'h0123, 1'b0, 1'b0, 1'b0, 15'h0000);
    idle(2);
    checkOutput("wait_tcam_vld", 32'(bus.res_vld), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 15'h0000, 1'b1, 1'b0, 1'b0, 15'h0000);
    checkOutput("lat_e0_vld", 32'(bus.res_vld), 32'd0);
    idle(1);
    checkOutput("lat_e1_vld", 32'(bus.res_vld), 32'd0);
    idle(1);
    checkOutput("lat_e2_vld", 32'(bus.res_vld), 32'd1);
    idle(2);
    checkCounters("hashonly", 1, 0, 0, 0);

    $display("[TB] both hit and tcam-only hit");
    pushExp(1'b0, 1'b1, 1'b0, 15'h0010);
    applyStimulus(1'b1, 1'b0, 1'b1, 15'h0010, 1'b1, 1'b0, 1'b1, 15'h7FFF);
    pushExp(1'b0, 1'b1, 1'b1, 15'h7FFF);
    applyStimulus(1'b1, 1'b0, 1'b0, 15'h0555, 1'b1, 1'b0, 1'b1, 15'h7FFF);
    idle(5);
    checkCounters("bothhit", 2, 1, 0, 0);

    $display("[TB] error priority");
    pushExp(1'b1, 1'b0, 1'b0, 15'h0000);
    applyStimulus(1'b1, 1'b1, 1'b0, 15'h0001, 1'b1, 1'b0, 1'b1, 15'h0042);
    pushExp(1'b1, 1'b0, 1'b0, 15'h0000);
    applyStimulus(1'b1, 1'b0, 1'b1, 15'h0033, 1'b1, 1'b1, 1'b1, 15'h0044);
    idle(5);
    checkCounters("err", 2, 1, 0, 2);
    pulseClear();
    checkCounters("clr", 0, 0, 0, 0);

    $display("[TB] backpressure");
    bus.res_ready = 1'b0;
    checkOutput("bp_afull_before", 32'(merge_afull), 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        pushExp(1'b0, 1'b1, 1'b0, 15'(16'h0100 + i));
        applyStimulus(1'b1, 1'b0, 1'b1, 15'(16'h0100 + i), 1'b1, 1'b0, 1'b1, 15'(16'h0200 + i));
      end else begin
        pushExp(1'b0, 1'b1, 1'b1, 15'(16'h0200 + i));
        applyStimulus(1'b1, 1'b0, 1'b0, 15'(16'h0100 + i), 1'b1, 1'b0, 1'b1, 15'(16'h0200 + i));
      end
    end
    idle(3);
    checkOutput("bp_afull", 32'(merge_afull), 32'd1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("bp_hold", 32'({bus.res_vld, bus.res_err, bus.res_hit, bus.res_src, bus.res_ptr}),
                  32'({1'b1, 1'b0, 1'b1, 1'b0, 15'h0100}));
      idle(1);
    end
    bus.res_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      idle(1);
      checkOutput("b2b_vld", 32'(bus.res_vld), 32'd1);
    end
    idle(1);
    checkOutput("drain_vld", 32'(bus.res_vld), 32'd0);
    checkOutput("bp_ovf", 32'(ovf_sticky), 32'd0);
    checkOutput("bp_afull_after", 32'(merge_afull), 32'd0);
    checkCounters("bp", 4, 4, 0, 0);

    $display("[TB] counter saturation and clear");
    pulseClear();
    for (int i = 0; i < 15; i++) begin
      pushExp(1'b0, 1'b0, 1'b0, 15'h0000);
      applyStimulus(1'b1, 1'b0, 1'b0, 15'h0ABC, 1'b1, 1'b0, 1'b0, 15'h0DEF);
    end
    idle(5);
    checkCounters("miss15", 0, 0, 15, 0);
    pushExp(1'b0, 1'b0, 1'b0, 15'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 15'h0ABC, 1'b1, 1'b0, 1'b0, 15'h0DEF);
    idle(5);
    checkOutput("miss_sat", 32'(cnt_miss), 32'd15);
    pushExp(1'b0, 1'b0, 1'b0, 15'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 15'h0001, 1'b1, 1'b0, 1'b0, 15'h0002);
    idle(2);
    checkOutput("clr_hs_vld", 32'(bus.res_vld), 32'd1);
    pulseClear();
    checkOutput("clr_hs_done", 32'(bus.res_vld), 32'd0);
    checkCounters("clr_hs", 0, 0, 0, 0);

    $display("[TB] hash fifo overflow");
    for (int i = 0; i < 10; i++) begin
      if (i < 8) pushExp(1'b0, 1'b1, 1'b0, 15'(16'h0300 + i));
      applyStimulus(1'b1, 1'b0, 1'b1, 15'(16'h0300 + i), 1'b0, 1'b0, 1'b0, 15'h0000);
    end
    idle(3);
    checkOutput("ovf_set", 32'(ovf_sticky), 32'b01);
    checkOutput("ovf_vld", 32'(bus.res_vld), 32'd0);
    checkOutput("ovf_afull", 32'(merge_afull), 32'd1);
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 15'h0000, 1'b1, 1'b0, 1'b0, 15'h0000);
    idle(6);
    checkOutput("ovf_drain_vld", 32'(bus.res_vld), 32'd0);
    checkOutput("ovf_sticky_kept", 32'(ovf_sticky), 32'b01);
    checkOutput("ovf_cnt_hash", 32'(cnt_hash_hit), 32'd8);

    $display("[TB] mid-operation reset");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b0, 1'b1, 15'h0777, 1'b0, 1'b0, 1'b0, 15'h0000);
    idle(2);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    checkOutput("mrst_ovf", 32'(ovf_sticky), 32'd0);
    checkOutput("mrst_afull", 32'(merge_afull), 32'd0);
    checkCounters("mrst", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 15'h0000, 1'b1, 1'b0, 1'b0, 15'h0000);
    idle(5);
    checkOutput("mrst_no_result", 32'(bus.res_vld), 32'd0);

    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/class_result_merge.md
Name: class_result_merge

Overview:
Downstream of the key-compare stage, alongside the OF TCAM. Accepts one single-cycle final result per packet from the key-compare stage and one from the OF TCAM, which arrive with independent latency. Each source is buffered in its own in-order FIFO. The block pairs the head entries, resolves priority (exact-match hash hit over TCAM wildcard hit), and presents one classification result per packet on a valid/ready interface. It also maintains saturating statistics counters and an upstream almost-full throttle.

Parameters:
VT_AWIDTH, 15, width of FID/TID pointer
DEPTH, 8, entries per input FIFO (power of 2, >=4)
AFULL_MARGIN, 2, afull asserts when either FIFO count >= DEPTH-AFULL_MARGIN
CNT_WIDTH, 32, statistics counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
hash_vld  in  1  key-compare final result strobe, one cycle per packet
hash_err  in  1  key-compare error (multiple matches)
hash_hit_miss  in  1  1=exact-match hit
hash_ptr  in  VT_AWIDTH  exact-match FID/TID
tcam_vld  in  1  OF TCAM result strobe, one cycle per packet
tcam_err  in  1  OF TCAM error
tcam_hit_miss  in  1  1=TCAM hit
tcam_ptr  in  VT_AWIDTH  TCAM FID/TID
res_vld  out  1  result valid
res_ready  in  1  downstream accept
res_err  out  1  merged error
res_hit  out  1  merged hit
res_src  out  1  0=hash, 1=TCAM (valid when res_hit)
res_ptr  out  VT_AWIDTH  merged FID/TID, 0 on miss/err
merge_afull  out  1  upstream throttle, registered
ovf_sticky  out  2  [0]=hash FIFO overflow, [1]=TCAM FIFO overflow, sticky
cnt_clr  in  1  synchronous clear of all counters
cnt_hash_hit  out  CNT_WIDTH  results with res_src=0, res_hit=1
cnt_tcam_hit  out  CNT_WIDTH  results with res_src=1, res_hit=1
cnt_miss  out  CNT_WIDTH  results with res_hit=0, res_err=0
cnt_err  out  CNT_WIDTH  results with res_err=1

Behaviour:
- Reset: all outputs 0; FIFOs empty; counters 0; ovf_sticky cleared (cleared only by reset).
- Push: each *_vld pushes {err, hit_miss, ptr} into its FIFO on the sampling edge. A pushed entry is visible at the head from the next cycle.
- Full FIFO with push and no pop: entry dropped, corresponding ovf_sticky bit set. Push and pop in the same cycle on a full FIFO is legal: no drop, count unchanged.
- Pair/load condition: both FIFOs non-empty AND (!res_vld || res_ready). When true, pop both heads and load the output register on that edge.
- Minimum latency: second input of a pair sampled at edge E -> res_vld high after edge E+2.
- Output register holds all res_* stable while res_vld && !res_ready.
- Back-to-back operation: with res_ready held high and both FIFOs non-empty, one result per cycle.
- res_vld deasserts after a handshake if no pair is available.
- Merge rule, in priority order:
  - Either err set -> res_err=1, res_hit=0, res_src=0, res_ptr=0.
  - Else hash hit -> res_hit=1, res_src=0, res_ptr=hash_ptr. The TCAM result is discarded even if it also hit.
  - Else TCAM hit -> res_hit=1, res_src=1, res_ptr=tcam_ptr.
  - Else -> all zero (miss).
- Counters:
  - Exactly one counter increments per handshake (res_vld && res_ready), matching the category of the presented result.
  - Counters saturate at all-ones.
  - cnt_clr wins over a same-cycle increment; value reads 0 next cycle.
- merge_afull: registered from the FIFO counts after the current push/pop. Upstream must stop issuing new lookups while it is high. In-flight results up to AFULL_MARGIN are absorbed.
- Mid-operation reset: FIFO contents, the output register and the counters are discarded without flush or handshake.

Decomposition:
- class_pkg holds:
  - typedef class_res_t = {err, hit_miss, ptr[VT_AWIDTH]}.
  - Constants RES_SRC_HASH=1'b0 and RES_SRC_TCAM=1'b1.
- Sub-module class_res_fifo (parameters WIDTH, DEPTH; ports push, din, pop, dout, empty, full, count), instanced twice.
- Counters and the merge stay in the top level.

Test Plan:
- Hash-only hit: hash hit ptr=0x0123 at cycle 0, TCAM miss at cycle 3, res_ready=1 -> res_vld at cycle 5 with hit=1, src=0, ptr=0x0123; cnt_hash_hit=1.
- Both hit: hash ptr=0x0010 and TCAM ptr=0x7FFF -> res_ptr=0x0010, src=0. Hash miss with TCAM hit ptr=0x7FFF -> res_ptr=0x7FFF, src=1; cnt_tcam_hit=1.
- Error priority: hash_err=1 with TCAM hit ptr=0x0042 -> res_err=1, res_hit=0, res_ptr=0; cnt_err=1.
- Backpressure: 8 hash and 8 TCAM results pushed with res_ready=0 -> merge_afull high once count reaches 6. Result 1 held stable. Then res_ready=1 -> 8 results in push order, one per cycle, no ovf_sticky.
- Overflow: 10 hash pushes with no TCAM results -> ovf_sticky=2'b01, hash FIFO count=8, and the sticky bit stays set after the FIFO drains.
- Counter edge cases: cnt_miss preloaded via 2^CNT_WIDTH-1 misses (reduced CNT_WIDTH=4 build: 15 misses), then one more miss -> stays 15. cnt_clr asserted on the same cycle as a handshake -> all counters 0 next cycle.
